// File: rtl/dcache_2way_wb.sv
// dcache_2way_wb: 2-way set-associative, write-back, write-allocate data cache; optional flush engine under DCACHE_FLUSH_EN.
// Latency: hit read data is registered one clock after the request; a miss stalls through write-back, refill and a 1-cycle replay.
// Backpressure: ram_abort stalls the CPU, which holds its inputs; DRAM words advance only on dram_wr_val / dram_rd_val.
module dcache_2way_wb #(
    parameter int ADDR_W     = 32,
    parameter int SET_BITS   = 7,
    parameter int LINE_WORDS = 8
) (
    input  logic              clock,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              data_req,
    input  logic              wren,
    input  logic [3:0]        cpu_byte_en,
    input  logic [31:0]       cpu_wr_data,
    output logic [31:0]       cpu_rd_data,
    output logic              hit,
    output logic              ram_abort,
    output logic              dram_wr_req,
    output logic [ADDR_W-1:0] dram_wr_addr,
    output logic [31:0]       dram_wr_data,
    input  logic              dram_wr_val,
    output logic              dram_rd_req,
    output logic [ADDR_W-1:0] dram_rd_addr,
    input  logic [31:0]       dram_rd_data,
`ifdef DCACHE_FLUSH_EN
    input  logic              flush_req,
    output logic              flush_done,
`endif
    input  logic              dram_rd_val
);
    localparam int WB       = $clog2(LINE_WORDS);
    localparam int OFF_BITS = WB + 2;
    localparam int TAG_W    = ADDR_W - SET_BITS - OFF_BITS;
    localparam int SETS     = 1 << SET_BITS;
    localparam logic [WB-1:0] LAST_WORD = WB'(LINE_WORDS - 1);

`ifdef DCACHE_FLUSH_EN
    typedef enum logic [2:0] {S_IDLE, S_WRITEBACK, S_REFILL, S_REPLAY, S_FLUSH} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_WRITEBACK, S_REFILL, S_REPLAY} state_t;
`endif

    // Line storage is never cleared; valid bits alone decide residency.
    logic [31:0]      data_mem [2][SETS*LINE_WORDS];
    logic [TAG_W-1:0] tag_mem  [2][SETS];

    state_t               state_q, state_d;
    logic [1:0][SETS-1:0] valid_q, valid_d, dirty_q, dirty_d;
    logic [SETS-1:0]      lru_q, lru_d;
    logic [TAG_W-1:0]     cap_tag_q, cap_tag_d;
    logic [SET_BITS-1:0]  cap_set_q, cap_set_d;
    logic [WB-1:0]        cap_word_q, cap_word_d;
    logic [31:0]          cap_dat_q, cap_dat_d;
    logic [3:0]           cap_be_q, cap_be_d;
    logic                 cap_wr_q, cap_wr_d;
    logic                 victim_q, victim_d;
    logic [WB-1:0]        wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
    logic [31:0]          rd_data_q, rd_data_d;
`ifdef DCACHE_FLUSH_EN
    logic [SET_BITS-1:0]  fl_set_q, fl_set_d;
    logic                 fl_way_q, fl_way_d;
    logic                 flush_done_q, flush_done_d;
    logic                 fl_dirty;
`endif

    logic [TAG_W-1:0]    cpu_tag;
    logic [SET_BITS-1:0] cpu_set, acc_set, wb_set;
    logic [WB-1:0]       cpu_word, acc_word;
    logic [1:0]          way_match;
    logic                lookup, victim_new, wb_way;
    logic                acc_vld, acc_way, acc_wr;
    logic [3:0]          acc_be;
    logic [31:0]         acc_dat;
    logic                unused_addr_lsbs;

    assign cpu_tag  = cpu_addr[ADDR_W-1:OFF_BITS+SET_BITS];
    assign cpu_set  = cpu_addr[OFF_BITS+SET_BITS-1:OFF_BITS];
    assign cpu_word = cpu_addr[OFF_BITS-1:2];
    assign unused_addr_lsbs = ^cpu_addr[1:0];

    // Tag compare on both ways of the addressed set
    always_comb begin
        for (int w = 0; w < 2; w++) begin
            way_match[w] = valid_q[w][cpu_set] && (tag_mem[w][cpu_set] == cpu_tag);
        end
    end

`ifdef DCACHE_FLUSH_EN
    assign lookup    = data_req && (state_q == S_IDLE) && !flush_req;
    assign ram_abort = (state_q != S_IDLE) || (lookup && !(|way_match)) || ((state_q == S_IDLE) && flush_req);
    assign fl_dirty  = valid_q[fl_way_q][fl_set_q] && dirty_q[fl_way_q][fl_set_q];
    assign dram_wr_req = (state_q == S_WRITEBACK) || ((state_q == S_FLUSH) && fl_dirty);
    assign flush_done  = flush_done_q;
`else
    assign lookup    = data_req && (state_q == S_IDLE);
    assign ram_abort = (state_q != S_IDLE) || (lookup && !(|way_match));
    assign dram_wr_req = (state_q == S_WRITEBACK);
`endif
    assign hit         = lookup && (|way_match);
    assign dram_rd_req = (state_q == S_REFILL);
    assign cpu_rd_data = rd_data_q;
    // An invalid way is always preferred over evicting a resident line.
    assign victim_new  = !valid_q[0][cpu_set] ? 1'b0 : (!valid_q[1][cpu_set] ? 1'b1 : lru_q[cpu_set]);

    // Write-back source: the miss victim, or the line under the flush cursor
    always_comb begin
        wb_way = victim_q;
        wb_set = cap_set_q;
`ifdef DCACHE_FLUSH_EN
        if (state_q == S_FLUSH) begin
            wb_way = fl_way_q;
            wb_set = fl_set_q;
        end
`endif
    end

    assign dram_wr_data = data_mem[wb_way][{wb_set, wr_cnt_q}];
    assign dram_wr_addr = {tag_mem[wb_way][wb_set], wb_set, {OFF_BITS{1'b0}}};
    assign dram_rd_addr = {cap_tag_q, cap_set_q, {OFF_BITS{1'b0}}};

    // A cache access is either a hit in IDLE or the replay of the captured miss
    always_comb begin
        acc_vld  = hit;
        acc_way  = way_match[1];
        acc_set  = cpu_set;
        acc_word = cpu_word;
        acc_wr   = wren;
        acc_be   = cpu_byte_en;
        acc_dat  = cpu_wr_data;
        if (state_q == S_REPLAY) begin
            acc_vld  = 1'b1;
            acc_way  = victim_q;
            acc_set  = cap_set_q;
            acc_word = cap_word_q;
            acc_wr   = cap_wr_q;
            acc_be   = cap_be_q;
            acc_dat  = cap_dat_q;
        end
    end

    // Next-state logic for the controller and the valid/dirty/LRU bits
    always_comb begin
        state_d    = state_q;
        valid_d    = valid_q;
        dirty_d    = dirty_q;
        lru_d      = lru_q;
        cap_tag_d  = cap_tag_q;
        cap_set_d  = cap_set_q;
        cap_word_d = cap_word_q;
        cap_dat_d  = cap_dat_q;
        cap_be_d   = cap_be_q;
        cap_wr_d   = cap_wr_q;
        victim_d   = victim_q;
        wr_cnt_d   = wr_cnt_q;
        rd_cnt_d   = rd_cnt_q;
        rd_data_d  = rd_data_q;
`ifdef DCACHE_FLUSH_EN
        fl_set_d     = fl_set_q;
        fl_way_d     = fl_way_q;
        flush_done_d = 1'b0;
`endif
        if (acc_vld) begin
            lru_d[acc_set] = ~acc_way;
            if (acc_wr) begin
                if (|acc_be) dirty_d[acc_way][acc_set] = 1'b1;
            end else begin
                rd_data_d = data_mem[acc_way][{acc_set, acc_word}];
            end
        end
        case (state_q)
            S_IDLE: begin
`ifdef DCACHE_FLUSH_EN
                if (flush_req) begin
                    state_d  = S_FLUSH;
                    fl_set_d = '0;
                    fl_way_d = 1'b0;
                end else
`endif
                if (lookup && !(|way_match)) begin
                    cap_tag_d  = cpu_tag;
                    cap_set_d  = cpu_set;
                    cap_word_d = cpu_word;
                    cap_dat_d  = cpu_wr_data;
                    cap_be_d   = cpu_byte_en;
                    cap_wr_d   = wren;
                    victim_d   = victim_new;
                    state_d    = (valid_q[victim_new][cpu_set] && dirty_q[victim_new][cpu_set])
                                 ? S_WRITEBACK : S_REFILL;
                end
            end
            S_WRITEBACK: begin
                if (dram_wr_val) begin
                    if (wr_cnt_q == LAST_WORD) begin
                        wr_cnt_d = '0;
                        state_d  = S_REFILL;
                    end else begin
                        wr_cnt_d = wr_cnt_q + WB'(1);
                    end
                end
            end
            S_REFILL: begin
                if (dram_rd_val) begin
                    if (rd_cnt_q == LAST_WORD) begin
                        rd_cnt_d                      = '0;
                        valid_d[victim_q][cap_set_q] = 1'b1;
                        dirty_d[victim_q][cap_set_q] = 1'b0;
                        state_d                       = S_REPLAY;
                    end else begin
                        rd_cnt_d = rd_cnt_q + WB'(1);
                    end
                end
            end
            S_REPLAY: state_d = S_IDLE;
`ifdef DCACHE_FLUSH_EN
            S_FLUSH: begin
                // Clean lines advance the cursor at once; dirty ones first stream out.
                if (!fl_dirty || (dram_wr_val && wr_cnt_q == LAST_WORD)) begin
                    wr_cnt_d = '0;
                    if (fl_dirty) dirty_d[fl_way_q][fl_set_q] = 1'b0;
                    if (!fl_way_q) begin
                        fl_way_d = 1'b1;
                    end else if (fl_set_q == SET_BITS'(SETS - 1)) begin
                        state_d      = S_IDLE;
                        flush_done_d = 1'b1;
                    end else begin
                        fl_way_d = 1'b0;
                        fl_set_d = fl_set_q + SET_BITS'(1);
                    end
                end else if (dram_wr_val) begin
                    wr_cnt_d = wr_cnt_q + WB'(1);
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // Line and tag storage: refill words land in place, hits/replays merge byte lanes
    always_ff @(posedge clock) begin
        if (state_q == S_REFILL && dram_rd_val) begin
            data_mem[victim_q][{cap_set_q, rd_cnt_q}] <= dram_rd_data;
            if (rd_cnt_q == LAST_WORD) tag_mem[victim_q][cap_set_q] <= cap_tag_q;
        end
        if (acc_vld && acc_wr) begin
            for (int b = 0; b < 4; b++) begin
                if (acc_be[b]) data_mem[acc_way][{acc_set, acc_word}][8*b +: 8] <= acc_dat[8*b +: 8];
            end
        end
    end

    // Controller state; reset abandons any line transfer and invalidates every set
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            valid_q    <= '0;
            dirty_q    <= '0;
            lru_q      <= '0;
            cap_tag_q  <= '0;
            cap_set_q  <= '0;
            cap_word_q <= '0;
            cap_dat_q  <= '0;
            cap_be_q   <= '0;
            cap_wr_q   <= 1'b0;
            victim_q   <= 1'b0;
            wr_cnt_q   <= '0;
            rd_cnt_q   <= '0;
            rd_data_q  <= '0;
`ifdef DCACHE_FLUSH_EN
            fl_set_q     <= '0;
            fl_way_q     <= 1'b0;
            flush_done_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            valid_q    <= valid_d;
            dirty_q    <= dirty_d;
            lru_q      <= lru_d;
            cap_tag_q  <= cap_tag_d;
            cap_set_q  <= cap_set_d;
            cap_word_q <= cap_word_d;
            cap_dat_q  <= cap_dat_d;
            cap_be_q   <= cap_be_d;
            cap_wr_q   <= cap_wr_d;
            victim_q   <= victim_d;
            wr_cnt_q   <= wr_cnt_d;
            rd_cnt_q   <= rd_cnt_d;
            rd_data_q  <= rd_data_d;
`ifdef DCACHE_FLUSH_EN
            fl_set_q     <= fl_set_d;
            fl_way_q     <= fl_way_d;
            flush_done_q <= flush_done_d;
`endif
        end
    end
endmodule

// File: tb/tb_dcache_2way_wb.sv
// tb_dcache_2way_wb: randomized bench with a line-level cache/DRAM model for dcache_2way_wb.
// Latency: one access at a time; the bench acts as DRAM with random 0-5 cycle gaps between words.
// Backpressure: the CPU side holds its request while ram_abort is high, as the cache expects.
module tb_dcache_2way_wb;
    localparam int SB   = 7;
    localparam int LW   = 8;
    localparam int OFF  = 5;
    localparam int SETS = 1 << SB;

    logic        clock, rst_n;
    logic [31:0] cpu_addr, cpu_wr_data, cpu_rd_data;
    logic        data_req, wren, hit, ram_abort;
    logic [3:0]  cpu_byte_en;
    logic        dram_wr_req, dram_wr_val, dram_rd_req, dram_rd_val;
    logic [31:0] dram_wr_addr, dram_wr_data, dram_rd_addr, dram_rd_data;
`ifdef DCACHE_FLUSH_EN
    logic        flush_req, flush_done;
`endif

    dcache_2way_wb #(.ADDR_W(32), .SET_BITS(SB), .LINE_WORDS(LW)) dut (
        .clock(clock), .rst_n(rst_n), .cpu_addr(cpu_addr), .data_req(data_req), .wren(wren),
        .cpu_byte_en(cpu_byte_en), .cpu_wr_data(cpu_wr_data), .cpu_rd_data(cpu_rd_data),
        .hit(hit), .ram_abort(ram_abort), .dram_wr_req(dram_wr_req), .dram_wr_addr(dram_wr_addr),
        .dram_wr_data(dram_wr_data), .dram_wr_val(dram_wr_val), .dram_rd_req(dram_rd_req),
        .dram_rd_addr(dram_rd_addr), .dram_rd_data(dram_rd_data),
`ifdef DCACHE_FLUSH_EN
        .flush_req(flush_req), .flush_done(flush_done),
`endif
        .dram_rd_val(dram_rd_val)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Behavioural model: DRAM as a sparse word map, cache as per-set line records.
    logic [31:0] dram_m [logic [31:0]];
    bit          m_valid [SETS][2];
    bit          m_dirty [SETS][2];
    logic [31:0] m_tag   [SETS][2];
    logic [31:0] m_data  [SETS][2][LW];
    bit          m_lru   [SETS];
    bit          m_hit, m_wb;
    logic [31:0] m_wb_addr, m_rd_addr, m_rdata;
    logic [31:0] m_wb_line [LW];
    bit          obs_miss, obs_wb_seen;
    logic [31:0] obs_rdata, obs_wb_addr, obs_wb_word1, obs_rd_addr;

    function automatic logic [31:0] dram_get(input logic [31:0] a);
        if (dram_m.exists(a)) return dram_m[a];
        return {a[15:0], ~a[15:0]};
    endfunction

    task automatic model_reset();
        for (int s = 0; s < SETS; s++) begin
            m_lru[s] = 1'b0;
            for (int w = 0; w < 2; w++) begin
                m_valid[s][w] = 1'b0;
                m_dirty[s][w] = 1'b0;
            end
        end
    endtask

    task automatic model_access(input logic [31:0] a, input bit wr, input logic [3:0] be, input logic [31:0] d);
        int s, wd, way;
        logic [31:0] tg;
        s  = int'(a[OFF+SB-1:OFF]);
        wd = int'(a[OFF-1:2]);
        tg = a >> (OFF + SB);
        way = -1;
        for (int i = 0; i < 2; i++) if (m_valid[s][i] && m_tag[s][i] == tg) way = i;
        m_hit = (way >= 0);
        m_wb  = 1'b0;
        if (!m_hit) begin
            if (!m_valid[s][0]) way = 0;
            else if (!m_valid[s][1]) way = 1;
            else way = int'(m_lru[s]);
            if (m_valid[s][way] && m_dirty[s][way]) begin
                m_wb      = 1'b1;
                m_wb_addr = (m_tag[s][way] << (OFF + SB)) | (s << OFF);
                for (int i = 0; i < LW; i++) begin
                    m_wb_line[i] = m_data[s][way][i];
                    dram_m[m_wb_addr + 4*i] = m_data[s][way][i];
                end
            end
            m_rd_addr = a & ~((32'h1 << OFF) - 1);
            for (int i = 0; i < LW; i++) m_data[s][way][i] = dram_get(m_rd_addr + 4*i);
            m_valid[s][way] = 1'b1;
            m_dirty[s][way] = 1'b0;
            m_tag[s][way]   = tg;
        end
        if (wr) begin
            for (int b = 0; b < 4; b++) if (be[b]) m_data[s][way][wd][8*b +: 8] = d[8*b +: 8];
            if (be != 4'b0) m_dirty[s][way] = 1'b1;
        end else begin
            m_rdata = m_data[s][way][wd];
        end
        m_lru[s] = (way == 0);
    endtask

    // One CPU access; on a miss the bench serves the DRAM side and checks every transfer cycle.
    task automatic access(input logic [31:0] a, input bit wr, input logic [3:0] be, input logic [31:0] d);
        int wcnt, rcnt, gap;
        bit done, rd_seen;
        model_access(a, wr, be, d);
        obs_wb_seen = 1'b0; rd_seen = 1'b0;
        obs_wb_addr = '0; obs_wb_word1 = '0; obs_rd_addr = '0;
        @(negedge clock);
        cpu_addr = a; wren = wr; cpu_byte_en = be; cpu_wr_data = d; data_req = 1'b1;
        #1;
        chk("hit", hit, m_hit);
        chk("ram_abort_on_request", ram_abort, !m_hit);
        obs_miss = !hit;
        if (m_hit) begin
            @(negedge clock);
            if (!wr) chk("hit_rd_data", cpu_rd_data, m_rdata);
            chk("hit_no_dram_req", {dram_wr_req, dram_rd_req}, 2'b00);
        end else begin
            wcnt = 0; rcnt = 0; gap = 0; done = 1'b0;
            for (int cyc = 0; cyc < 400 && !done; cyc++) begin
                @(negedge clock);
                dram_wr_val = 1'b0; dram_rd_val = 1'b0; dram_rd_data = $urandom;
                if (!ram_abort) begin
                    done = 1'b1;
                end else if (dram_wr_req) begin
                    obs_wb_seen = 1'b1;
                    obs_wb_addr = dram_wr_addr;
                    chk("wb_expected", {dram_rd_req, m_wb && wcnt < LW}, 2'b01);
                    if (m_wb && wcnt < LW) begin
                        chk("wb_addr", dram_wr_addr, m_wb_addr);
                        chk("wb_data", dram_wr_data, m_wb_line[wcnt]);
                        if (wcnt == 1) obs_wb_word1 = dram_wr_data;
                        if (gap > 0) gap--;
                        else begin dram_wr_val = 1'b1; wcnt++; gap = int'($urandom_range(0, 5)); end
                    end
                    dram_rd_val = 1'($urandom_range(0, 1));
                end else if (dram_rd_req) begin
                    if (!rd_seen) begin
                        obs_rd_addr = dram_rd_addr;
                        chk("wb_done_before_refill", wcnt, m_wb ? LW : 0);
                        rd_seen = 1'b1;
                    end
                    chk("rd_addr", dram_rd_addr, m_rd_addr);
                    chk("refill_in_range", (rcnt < LW), 1'b1);
                    if (rcnt < LW) begin
                        if (gap > 0) gap--;
                        else begin
                            dram_rd_val = 1'b1; dram_rd_data = dram_get(m_rd_addr + 4*rcnt);
                            rcnt++; gap = int'($urandom_range(0, 5));
                        end
                    end
                    dram_wr_val = 1'($urandom_range(0, 1));
                end else begin
                    dram_wr_val = 1'($urandom_range(0, 1));
                    dram_rd_val = 1'($urandom_range(0, 1));
                end
            end
            dram_wr_val = 1'b0; dram_rd_val = 1'b0;
            chk("miss_completes", done, 1'b1);
            chk("wb_words", wcnt, m_wb ? LW : 0);
            chk("refill_words", rcnt, LW);
            chk("hit_after_replay", hit, 1'b1);
            if (!wr) chk("miss_rd_data", cpu_rd_data, m_rdata);
        end
        obs_rdata = cpu_rd_data;
        data_req = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        int cnt;
        logic [31:0] a;
        rst_n = 1'b0; data_req = 1'b0; wren = 1'b0; cpu_addr = '0; cpu_byte_en = '0; cpu_wr_data = '0;
        dram_wr_val = 1'b0; dram_rd_val = 1'b0; dram_rd_data = '0;
`ifdef DCACHE_FLUSH_EN
        flush_req = 1'b0;
`endif
        for (int i = 0; i < LW; i++) dram_m[32'h1000 + 4*i] = 32'hA0 + i;
        model_reset();
        repeat (3) @(negedge clock);
        chk("reset_rd_data", cpu_rd_data, 32'h0);
        chk("reset_ram_abort", ram_abort, 1'b0);
        chk("reset_dram_reqs", {dram_wr_req, dram_rd_req}, 2'b00);
        rst_n = 1'b1;

        // Cold read, then hits
        access(32'h1004, 1'b0, 4'h0, 32'h0);
        chk("t1_miss", obs_miss, 1'b1);
        chk("t1_no_wb", obs_wb_seen, 1'b0);
        chk("t1_rd_addr", obs_rd_addr, 32'h1000);
        chk("t1_rdata", obs_rdata, 32'hA1);
        access(32'h1004, 1'b0, 4'h0, 32'h0);
        chk("t1_rehit", obs_miss, 1'b0);

        // Byte-enable write
        access(32'h1004, 1'b1, 4'b0011, 32'hDEADBEEF);
        access(32'h1004, 1'b0, 4'h0, 32'h0);
        chk("t2_merged", obs_rdata, 32'h0000BEEF);

        // Two lines in set 0
        access(32'h5000, 1'b0, 4'h0, 32'h0);
        chk("t3_5000_miss", obs_miss, 1'b1);
        chk("t3_5000_no_wb", obs_wb_seen, 1'b0);
        access(32'h1000, 1'b0, 4'h0, 32'h0);
        chk("t3_1000_hit", obs_miss, 1'b0);
        access(32'h5000, 1'b0, 4'h0, 32'h0);
        chk("t3_5000_rehit", obs_miss, 1'b0);

        // Dirty eviction of 0x1000
        access(32'h5000, 1'b0, 4'h0, 32'h0);
        access(32'h9000, 1'b0, 4'h0, 32'h0);
        chk("t4_wb_seen", obs_wb_seen, 1'b1);
        chk("t4_wb_addr", obs_wb_addr, 32'h1000);
        chk("t4_wb_word1", obs_wb_word1, 32'h0000BEEF);
        chk("t4_rd_addr", obs_rd_addr, 32'h9000);
        access(32'h5000, 1'b0, 4'h0, 32'h0);
        chk("t4_5000_hit", obs_miss, 1'b0);

        // Reset in the middle of a refill
        @(negedge clock);
        cpu_addr = 32'h3040; wren = 1'b0; cpu_byte_en = 4'h0; data_req = 1'b1;
        cnt = 0;
        for (int c = 0; c < 50 && cnt < 3; c++) begin
            @(negedge clock);
            dram_rd_val = 1'b0;
            if (dram_rd_req) begin dram_rd_val = 1'b1; dram_rd_data = 32'h12340000 + cnt; cnt++; end
        end
        @(negedge clock);
        dram_rd_val = 1'b0;
        chk("t6_refill_active", dram_rd_req, 1'b1);
        rst_n = 1'b0; data_req = 1'b0;
        #1;
        chk("t6_rst_ram_abort", ram_abort, 1'b0);
        chk("t6_rst_dram_reqs", {dram_wr_req, dram_rd_req}, 2'b00);
        chk("t6_rst_rd_data", cpu_rd_data, 32'h0);
        @(negedge clock);
        rst_n = 1'b1;
        model_reset();
        access(32'h3040, 1'b0, 4'h0, 32'h0);
        chk("t6_3040_miss", obs_miss, 1'b1);
        access(32'h1004, 1'b0, 4'h0, 32'h0);
        chk("t6_1004_miss", obs_miss, 1'b1);
        chk("t6_1004_from_dram", obs_rdata, 32'h0000BEEF);

        // Random traffic over a few contended sets
        for (int n = 0; n < 300; n++) begin
            a = ($urandom_range(0, 5) << (OFF + SB)) | ($urandom_range(0, 3) << OFF) | ($urandom_range(0, LW-1) << 2);
            access(a, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
